// File: rtl/dose_controller_pkg.sv
// rtl/dose_controller_pkg.sv - shared channel indices, state encoding and defaults for the dose controller
package dose_controller_pkg;

  localparam logic [1:0] CH_R = 2'd2;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_B = 2'd0;

  localparam int DEFAULT_TICKS_PER_UNIT = 50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_ch(input logic [2:0] oh);
    logic [1:0] ch;
    case (oh)
      3'b100:  ch = CH_R;
      3'b010:  ch = CH_Y;
      default: ch = CH_B;
    endcase
    return ch;
  endfunction

  function automatic logic [2:0] ch_to_onehot(input logic [1:0] ch);
    return 3'b001 << ch;
  endfunction

endpackage

// File: rtl/dose_controller_unit_prescaler.sv
// rtl/dose_controller_unit_prescaler.sv - one-cycle tick every TICKS_PER_UNIT enabled cycles
module unit_prescaler
  import dose_controller_pkg::*;
#(
  parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_UNIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/dose_controller.sv
// rtl/dose_controller.sv - per-channel dosing motor controller driven by a one-hot load command
module dose_controller
  import dose_controller_pkg::*;
#(
  parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
  parameter int AMT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       motores,
  input  logic [AMT_W-1:0] amt_r,
  input  logic [AMT_W-1:0] amt_y,
  input  logic [AMT_W-1:0] amt_b,
  output logic [2:0]       flags,
  output logic [2:0]       motor_drive,
  output logic             busy,
  output logic             cmd_err
);

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [AMT_W-1:0] units_q, units_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       drive_q, drive_d;
  logic             busy_q, busy_d;
  logic             cmd_err_q, cmd_err_d;

  logic             cmd_onehot;
  logic             cmd_multi;
  logic             cmd_held;
  logic [2:0]       captured;
  logic [AMT_W-1:0] amt_sel;
  logic             unit_tick;

  assign cmd_onehot = $onehot(motores);
  assign cmd_multi  = (motores != 3'b000) && !cmd_onehot;
  assign captured   = ch_to_onehot(ch_q);
  assign cmd_held   = (motores == captured);

  always_comb begin
    case (motores)
      3'b100:  amt_sel = amt_r;
      3'b010:  amt_sel = amt_y;
      3'b001:  amt_sel = amt_b;
      default: amt_sel = '0;
    endcase
  end

  // The tick counter only runs while a dose is actively being delivered.
  unit_prescaler #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == ST_RUN && cmd_held),
    .clear(state_q != ST_RUN),
    .tick (unit_tick)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    units_d   = units_q;
    flags_d   = 3'b000;
    drive_d   = 3'b000;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_onehot) begin
          ch_d    = onehot_to_ch(motores);
          units_d = amt_sel;
          if (amt_sel == '0) begin
            state_d = ST_DONE;
            flags_d = motores;
          end else begin
            state_d = ST_RUN;
            drive_d = motores;
          end
        end else if (cmd_multi) begin
          cmd_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cmd_held) begin
          state_d = ST_IDLE;
          units_d = '0;
        end else if (unit_tick && units_q <= AMT_W'(1)) begin
          state_d = ST_DONE;
          units_d = '0;
          flags_d = captured;
        end else begin
          drive_d = captured;
          if (unit_tick) begin
            units_d = units_q - AMT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (cmd_held) begin
          flags_d = captured;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        units_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_B;
      units_q   <= '0;
      flags_q   <= 3'b000;
      drive_q   <= 3'b000;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      units_q   <= units_d;
      flags_q   <= flags_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign flags       = flags_q;
  assign motor_drive = drive_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_dose_controller.sv
// tb/tb_dose_controller.sv - self-checking bench for dose_controller with TICKS_PER_UNIT=4, AMT_W=4
module tb_dose_controller;

  localparam int T  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    motores = 3'b000;
  logic [AW-1:0] amt_r = '0, amt_y = '0, amt_b = '0;
  logic [2:0]    flags, motor_drive;
  logic          busy, cmd_err;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [2:0] mask;
    int         len;
  } pulse_t;
  pulse_t exp_q[$];

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] ar, ay, ab;
    int            len;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  dose_controller #(.TICKS_PER_UNIT(T), .AMT_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .motores    (motores),
    .amt_r      (amt_r),
    .amt_y      (amt_y),
    .amt_b      (amt_b),
    .flags      (flags),
    .motor_drive(motor_drive),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Drive-pulse monitor: each completed pulse is compared against the scoreboard.
  logic [2:0] prev_drive = 3'b000;
  int         run_len = 0;
  always @(negedge clk) begin
    pulse_t e;
    logic   ok;
    ok = $onehot0(flags) && $onehot0(motor_drive) && !((|flags) && (|motor_drive));
    check("invariant", 32'(ok), 32'd1);
    if (prev_drive != 3'b000 && motor_drive != prev_drive) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", 32'(prev_drive), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_mask", 32'(prev_drive), 32'(e.mask));
        check("pulse_len", 32'(run_len), 32'(e.len));
      end
    end
    if (motor_drive != 3'b000) run_len = (motor_drive == prev_drive) ? run_len + 1 : 1;
    prev_drive = motor_drive;
  end

  task automatic wait_flags(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 2) begin
        amt_r = AW'($urandom);
        amt_y = AW'($urandom);
        amt_b = AW'($urandom);
      end
      if (flags != 3'b000) begin
        lat = k;
        return;
      end
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{3'b100, 4'd3, 4'd0, 4'd0, 12};
    vecs[1] = '{3'b010, 4'd0, 4'd0, 4'd0, 0};
    vecs[2] = '{3'b100, 4'd1, 4'd2, 4'd1, 4};
    vecs[3] = '{3'b010, 4'd1, 4'd2, 4'd1, 8};
    vecs[4] = '{3'b001, 4'd1, 4'd2, 4'd1, 4};
    vecs[5] = '{3'b100, 4'd15, 4'd0, 4'd0, 60};

    repeat (3) @(negedge clk);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_drive", 32'(motor_drive), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    reset = 1'b1;

    motores = 3'b110;
    @(negedge clk);
    check("err_pulse", 32'(cmd_err), 32'd1);
    check("err_drive", 32'(motor_drive), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    motores = 3'b000;
    @(negedge clk);
    check("err_clear", 32'(cmd_err), 32'd0);
    check("err_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      amt_r   = vecs[i].ar;
      amt_y   = vecs[i].ay;
      amt_b   = vecs[i].ab;
      motores = vecs[i].cmd;
      if (vecs[i].len > 0) exp_q.push_back('{vecs[i].cmd, vecs[i].len});
      if (i > 0) begin
        @(negedge clk);
        check("release_flags", 32'(flags), 32'd0);
      end
      wait_flags(200, lat);
      check("flag_latency", 32'(lat), 32'(vecs[i].len + 1));
      check("flag_value", 32'(flags), 32'(vecs[i].cmd));
      check("done_busy", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      check("flag_hold", 32'(flags), 32'(vecs[i].cmd));
    end
    motores = 3'b000;
    @(negedge clk);
    check("final_release", 32'(flags), 32'd0);
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    amt_b   = 4'd5;
    motores = 3'b001;
    exp_q.push_back('{3'b001, 7});
    repeat (7) @(negedge clk);
    motores = 3'b000;
    @(negedge clk);
    check("abort_drive", 32'(motor_drive), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_no_flag", 32'(flags), 32'd0);
    amt_b   = 4'd5;
    motores = 3'b001;
    exp_q.push_back('{3'b001, 20});
    wait_flags(200, lat);
    check("restart_latency", 32'(lat), 32'd21);
    check("restart_flags", 32'(flags), 32'd1);
    motores = 3'b000;
    repeat (2) @(negedge clk);

    amt_r   = 4'd2;
    motores = 3'b100;
    exp_q.push_back('{3'b100, 3});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstrun_drive", 32'(motor_drive), 32'd0);
    check("rstrun_flags", 32'(flags), 32'd0);
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_cmd_err", 32'(cmd_err), 32'd0);
    reset = 1'b1;
    amt_r = 4'd2;
    exp_q.push_back('{3'b100, 8});
    wait_flags(200, lat);
    check("rstrun_latency", 32'(lat), 32'd9);
    check("rstrun_done", 32'(flags), 32'd4);
    motores = 3'b000;
    repeat (3) @(negedge clk);

    check("pulses_outstanding", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dose_controller.md
DOSE_CONTROLLER -- requirements
Module: dose_controller

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 50000, SHALL set the number of clk cycles per dose unit; legal range 1..2^20.
REQ-002 Parameter AMT_W, default 4, SHALL set the width of each per-channel dose amount.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 motores  input  3  one-hot load command from the sequencing FSM: bit 2 red, bit 1 yellow, bit 0 blue; 000 means no command.
REQ-006 amt_r, amt_y, amt_b  input  AMT_W each  requested dose, in units, for each channel.
REQ-007 flags  output  3  per-channel load-complete indication back to the sequencing FSM, using the same bit mapping as motores.
REQ-008 motor_drive  output  3  per-channel motor enable to the driver stage.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 cmd_err  output  1  one-cycle pulse when a multi-hot motores value is seen in IDLE.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; the channel index and the remaining-unit count SHALL be registered.
REQ-012 IDLE: when motores is one-hot, the block SHALL capture the channel and the matching amt_* value, then move to RUN, or to DONE if the amount is 0.
REQ-013 IDLE: when motores has more than one bit set, the block SHALL ignore the command, pulse cmd_err and stay in IDLE.
REQ-014 RUN: motor_drive[ch] SHALL be 1 and all other motor_drive bits 0.
REQ-015 RUN: motor_drive[ch] SHALL stay high for exactly amount*TICKS_PER_UNIT consecutive cycles, starting the cycle after capture.
REQ-016 RUN: the block SHALL then enter DONE.
REQ-017 DONE: flags[ch] SHALL be 1, all other flags bits 0, and motor_drive SHALL be 000.
REQ-018 DONE: flags[ch] SHALL hold while motores equals the captured one-hot value.
REQ-019 DONE: when motores differs from the captured value, the block SHALL clear flags and return to IDLE on the next edge.
REQ-020 A new command SHALL be accepted no earlier than the cycle after the return to IDLE.
REQ-021 RUN abort: if motores differs from the captured value, motor_drive SHALL drop on the next edge and the state SHALL return to IDLE.
REQ-022 RUN abort: flags SHALL NOT be asserted on an abort.
REQ-023 amt_* changes after capture SHALL have no effect on the current dose.
REQ-024 The unit counter SHALL be AMT_W bits and the tick counter ceil(log2(TICKS_PER_UNIT)) bits; neither counter SHALL wrap past zero.
REQ-025 flags, motor_drive and busy SHALL be registered outputs, with no combinational path from any input.
REQ-026 At most one flags bit and at most one motor_drive bit SHALL be 1 in any cycle.
REQ-027 flags and motor_drive SHALL never both be nonzero in the same cycle.

Reset
REQ-028 While reset is 0 at a clk edge, the state SHALL become IDLE, counters 0, and flags, motor_drive, busy and cmd_err 0.
REQ-029 Reset asserted mid-RUN SHALL turn off motor_drive at that edge, and the interrupted dose SHALL NOT resume.
REQ-030 After reset release, the first command SHALL be evaluable on the first clk edge with reset at 1.

Structure
REQ-031 The shared package SHALL hold: channel indices (r=2, y=1, b=0), the state encoding, and the default TICKS_PER_UNIT.
REQ-032 The per-unit tick generator SHALL be a sub-module, unit_prescaler (inputs: clk, reset, en, clear; output: one-cycle tick every TICKS_PER_UNIT enabled cycles).

Verification (TICKS_PER_UNIT=4, AMT_W=4)
REQ-033 Scenario 1: amt_r=3, motores=100 held -> motor_drive=100 for exactly 12 cycles, then flags=100 while the command is held; motores=010 -> flags=000 within 1 cycle.
REQ-034 Scenario 2: full sequence, amt_r=1, amt_y=2, amt_b=1, motores stepped 100 -> 010 -> 001 on each flag -> drive pulses of 4, 8 and 4 cycles; flags 100, 010, 001 in order; no overlap.
REQ-035 Scenario 3: amt_y=0, motores=010 -> motor_drive stays 000; flags=010 on the cycle after capture.
REQ-036 Scenario 4: motores=110 in IDLE -> cmd_err pulses 1 cycle; motor_drive=000; state IDLE.
REQ-037 Scenario 5: amt_b=5, motores=001, then motores=000 after 7 cycles -> motor_drive=000 next cycle; flags stay 000; the next command restarts the full count.
REQ-038 Scenario 6: reset=0 during RUN with amt_r=2 -> all outputs 0 at that edge; after release with motores=100 still held, a full 8-cycle dose runs.
